// File: rtl/pll_rst_cen_pkg.sv
// Shared types and phase constants for the PLL reset / clock-enable generator.
package pll_rst_cen_pkg;

  // Reset sequencer states.
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2
  } state_t;

  // One phase-counter period spans 12 clk cycles; the enables divide it down.
  localparam int unsigned PH_MOD    = 12;
  localparam int unsigned CEN12_DIV = 3;
  localparam int unsigned CEN6_DIV  = 6;
  localparam int unsigned PH_W      = 4;
  localparam int unsigned HOLD_W    = 16;

  // Next phase value, wrapping PH_MOD-1 back to 0.
  function automatic logic [PH_W-1:0] ph_inc(input logic [PH_W-1:0] ph);
    if (ph == PH_W'(PH_MOD - 1)) begin
      return '0;
    end
    return ph + PH_W'(1);
  endfunction

  // True when the phase value is a multiple of div (div divides PH_MOD).
  function automatic logic ph_hit(input logic [PH_W-1:0] ph, input int unsigned div);
    return (32'(ph) % div) == 32'd0;
  endfunction

endpackage

// File: rtl/pll_rst_cen_gen_lock_sync.sv
// Generic multi-flop synchroniser for signals arriving from another clock domain.
module lock_sync #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  // Shift the asynchronous input through the flop chain; rst clears every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_rst_cen_gen.sv
// Post-PLL reset sequencer and phase-aligned clock-enable generator (36 MHz domain).
module pll_rst_cen_gen
  import pll_rst_cen_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter int unsigned Q_PHASE     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic soft_rst,
  output logic core_rst,
  output logic cen_12,
  output logic cen_6,
  output logic cen_6q,
  output logic cen_3,
  output logic ready
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("pll_rst_cen_gen: SYNC_STAGES must be in 2..4");
  end
  if (HOLD_CYCLES < 16 || HOLD_CYCLES > 65535) begin : g_bad_hold_cycles
    $error("pll_rst_cen_gen: HOLD_CYCLES must be in 16..65535");
  end
  if (Q_PHASE < 1 || Q_PHASE > 5) begin : g_bad_q_phase
    $error("pll_rst_cen_gen: Q_PHASE must be in 1..5");
  end

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PH_W-1:0]   Q_PH_A    = PH_W'(Q_PHASE);
  localparam logic [PH_W-1:0]   Q_PH_B    = PH_W'(Q_PHASE + CEN6_DIV);

  logic              lock_s;
  state_t            state, nxt_state;
  logic [HOLD_W-1:0] hold, nxt_hold;
  logic [PH_W-1:0]   ph, nxt_ph;
  logic              core_rst_d, ready_d;
  logic              cen_12_d, cen_6_d, cen_6q_d, cen_3_d;

  lock_sync #(
    .STAGES(SYNC_STAGES),
    .WIDTH (1)
  ) u_lock_sync (
    .clk(clk),
    .rst(rst),
    .d  (pll_locked),
    .q  (lock_s)
  );

  // State, hold counter and phase counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_LOCK;
      hold  <= '0;
      ph    <= '0;
    end else begin
      state <= nxt_state;
      hold  <= nxt_hold;
      ph    <= nxt_ph;
    end
  end

  // Next-state logic: loss of lock beats soft_rst beats normal progression.
  always_comb begin
    nxt_state = state;
    nxt_hold  = hold;
    nxt_ph    = ph;
    unique case (state)
      WAIT_LOCK: begin
        nxt_hold = '0;
        nxt_ph   = '0;
        if (lock_s) begin
          nxt_state = STABILIZE;
        end
      end
      STABILIZE, RUN: begin
        if (!lock_s) begin
          nxt_state = WAIT_LOCK;
          nxt_hold  = '0;
          nxt_ph    = '0;
        end else if (soft_rst) begin
          nxt_state = STABILIZE;
          nxt_hold  = '0;
          nxt_ph    = '0;
        end else begin
          nxt_ph = ph_inc(ph);
          if (state == STABILIZE) begin
            if (hold == HOLD_LAST) begin
              nxt_state = RUN;
            end else begin
              nxt_hold = hold + HOLD_W'(1);
            end
          end
        end
      end
      default: begin
        nxt_state = WAIT_LOCK;
        nxt_hold  = '0;
        nxt_ph    = '0;
      end
    endcase
  end

  // Output decode from the next state/phase so the registered outputs line up
  // with the registered ph they describe (first STABILIZE cycle sees ph=0).
  always_comb begin
    core_rst_d = 1'b1;
    ready_d    = 1'b0;
    cen_12_d   = 1'b0;
    cen_6_d    = 1'b0;
    cen_6q_d   = 1'b0;
    cen_3_d    = 1'b0;
    if (nxt_state != WAIT_LOCK) begin
      cen_12_d = ph_hit(nxt_ph, CEN12_DIV);
      cen_6_d  = ph_hit(nxt_ph, CEN6_DIV);
      cen_3_d  = (nxt_ph == '0);
      cen_6q_d = (nxt_ph == Q_PH_A) || (nxt_ph == Q_PH_B);
    end
    if (nxt_state == RUN) begin
      core_rst_d = 1'b0;
      ready_d    = 1'b1;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_rst <= 1'b1;
      ready    <= 1'b0;
      cen_12   <= 1'b0;
      cen_6    <= 1'b0;
      cen_6q   <= 1'b0;
      cen_3    <= 1'b0;
    end else begin
      core_rst <= core_rst_d;
      ready    <= ready_d;
      cen_12   <= cen_12_d;
      cen_6    <= cen_6_d;
      cen_6q   <= cen_6q_d;
      cen_3    <= cen_3_d;
    end
  end

endmodule

// File: tb/tb_pll_rst_cen_gen.sv
// Self-checking bench for pll_rst_cen_gen: directed plan steps plus random lock/soft_rst traffic.
module tb_pll_rst_cen_gen;

  localparam int SYNC = 2;
  localparam int HOLD = 16;
  localparam int QPH  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;
  logic soft_rst = 1'b0;
  logic core_rst, cen_12, cen_6, cen_6q, cen_3, ready;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model: lock delay line plus "active since cycle m_start".
  bit lq[$];
  bit m_active = 1'b0;
  int m_start = 0;

  pll_rst_cen_gen #(
    .SYNC_STAGES(SYNC),
    .HOLD_CYCLES(HOLD),
    .Q_PHASE    (QPH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .soft_rst  (soft_rst),
    .core_rst  (core_rst),
    .cen_12    (cen_12),
    .cen_6     (cen_6),
    .cen_6q    (cen_6q),
    .cen_3     (cen_3),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance the model over one rising edge using the inputs presented to it.
  task automatic model_step();
    bit ls;
    cyc++;
    ls = lq[0];
    if (rst) begin
      m_active = 1'b0;
      lq.delete();
      repeat (SYNC) lq.push_back(1'b0);
    end else begin
      void'(lq.pop_front());
      lq.push_back(pll_locked);
      if (!m_active) begin
        if (ls) begin
          m_active = 1'b1;
          m_start  = cyc;
        end
      end else if (!ls) begin
        m_active = 1'b0;
      end else if (soft_rst) begin
        m_start = cyc;
      end
    end
  endtask

  task automatic check_outputs();
    int e, p;
    logic x_core, x_rdy, x12, x6, x6q, x3;
    x_core = 1'b1; x_rdy = 1'b0; x12 = 1'b0; x6 = 1'b0; x6q = 1'b0; x3 = 1'b0;
    if (m_active) begin
      e = cyc - m_start;
      p = e % 12;
      x_core = (e < HOLD);
      x_rdy  = !x_core;
      x12 = (p % 3 == 0);
      x6  = (p % 6 == 0);
      x3  = (p == 0);
      x6q = (p % 6 == QPH);
    end
    chk("core_rst", core_rst, x_core);
    chk("ready", ready, x_rdy);
    chk("cen_12", cen_12, x12);
    chk("cen_6", cen_6, x6);
    chk("cen_6q", cen_6q, x6q);
    chk("cen_3", cen_3, x3);
    chk("inv_cen3_implies_cen6", cen_3 & ~cen_6, 1'b0);
    chk("inv_cen6_implies_cen12", cen_6 & ~cen_12, 1'b0);
    chk("inv_cen6_cen6q_exclusive", cen_6 & cen_6q, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  // Tick until the selected output (0: cen_3, 1: ready) is 1; -1 on timeout.
  task automatic wait_for(input int sel, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((sel == 0 && cen_3 === 1'b1) || (sel == 1 && ready === 1'b1)) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int stab_at, rdy_at, last6;
    int n12, n6, n6q, n3;
    repeat (SYNC) lq.push_back(1'b0);

    // Reset then lock.
    rst = 1'b1;
    repeat (4) tick();
    chk("reset_core_rst", core_rst, 1'b1);
    chk("reset_ready", ready, 1'b0);
    chk("reset_cen_12", cen_12, 1'b0);
    rst = 1'b0;
    while (cyc < 10) tick();
    pll_locked = 1'b1;
    stab_at = -1;
    rdy_at = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (stab_at < 0 && cen_3 === 1'b1) begin
        stab_at = cyc;
        chk("first_stab_cen_12", cen_12, 1'b1);
        chk("first_stab_cen_6", cen_6, 1'b1);
        chk("first_stab_core_rst", core_rst, 1'b1);
      end
      if (ready === 1'b1) begin
        rdy_at = cyc;
        break;
      end
    end
    chk_int("first_stab_cycle", stab_at, 10 + SYNC + 1);
    chk_int("first_ready_cycle", rdy_at, 10 + SYNC + 1 + HOLD);

    // Cen cadence over 120 RUN cycles.
    n12 = 0; n6 = 0; n6q = 0; n3 = 0; last6 = -1;
    for (int i = 0; i < 120; i++) begin
      tick();
      chk("cadence_ready", ready, 1'b1);
      n12 += int'(cen_12 === 1'b1);
      n6  += int'(cen_6 === 1'b1);
      n6q += int'(cen_6q === 1'b1);
      n3  += int'(cen_3 === 1'b1);
      if (cen_6 === 1'b1) last6 = cyc;
      if (cen_6q === 1'b1 && last6 >= 0) chk_int("cen_6q_offset", cyc - last6, QPH);
    end
    chk_int("count_cen_12", n12, 40);
    chk_int("count_cen_6", n6, 20);
    chk_int("count_cen_6q", n6q, 20);
    chk_int("count_cen_3", n3, 10);

    // Lock loss in RUN for one cycle.
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    repeat (SYNC) tick();
    chk("lockloss_core_rst", core_rst, 1'b1);
    chk("lockloss_ready", ready, 1'b0);
    chk("lockloss_cen_12", cen_12, 1'b0);
    wait_for(0, 20, stab_at);
    wait_for(1, HOLD + 10, rdy_at);
    chk_int("lockloss_hold", rdy_at - stab_at, HOLD);

    // soft_rst pulse in RUN.
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    chk("soft_cen_3", cen_3, 1'b1);
    chk("soft_core_rst", core_rst, 1'b1);
    stab_at = cyc;
    wait_for(1, HOLD + 10, rdy_at);
    chk_int("soft_hold", rdy_at - stab_at, HOLD);

    // Lock glitch in the middle of STABILIZE.
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    repeat (8) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    repeat (SYNC) tick();
    chk("glitch_core_rst", core_rst, 1'b1);
    chk("glitch_cen_3", cen_3, 1'b0);
    wait_for(0, 20, stab_at);
    wait_for(1, HOLD + 10, rdy_at);
    chk_int("glitch_hold_restart", rdy_at - stab_at, HOLD);

    // soft_rst coinciding with loss of lock: WAIT_LOCK wins.
    pll_locked = 1'b0;
    repeat (SYNC) tick();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    chk("simul_core_rst", core_rst, 1'b1);
    chk("simul_ready", ready, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("simul_cens_idle", cen_12 | cen_6 | cen_6q | cen_3, 1'b0);
    end
    pll_locked = 1'b1;
    wait_for(1, HOLD + 20, rdy_at);
    chk("simul_relock_ready", ready, 1'b1);

    // Random lock drops, soft resets and occasional hard resets.
    for (int i = 0; i < 3000; i++) begin
      pll_locked = ($urandom_range(0, 40) != 0);
      soft_rst   = ($urandom_range(0, 60) == 0);
      rst        = ($urandom_range(0, 400) == 0);
      tick();
    end
    rst = 1'b0;
    soft_rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
